// File: rtl/store_unit.sv
// Store buffer between the memory stage and the DMEM write port: formats SB/SH/SW stores
// into lane-placed words with byte masks and drains them in order. Optional: STORE_HAZARD_EN.
module store_unit #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_st_valid,
  output logic              o_st_ready,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [31:0]       i_st_data,
  input  logic [2:0]        i_st_type,
  output logic              o_st_err,
  output logic              o_dmem_req,
  input  logic              i_dmem_ack,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_bmask,
  output logic              o_busy,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_hazard
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [31:0]       wdata;
    logic [3:0]        bmask;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  entry_t             fmt_c;
  logic               illegal_c;
  logic               full_c;
  logic               empty_c;
  logic               accept_c;
  logic               enq_c;
  logic               deq_c;

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign accept_c = i_st_valid && !full_c;
  assign enq_c    = accept_c && !illegal_c;
  assign deq_c    = !empty_c && i_dmem_ack;

  // Lane placement, byte mask and legality of the incoming store
  always_comb begin
    fmt_c      = '0;
    illegal_c  = 1'b0;
    fmt_c.word = i_st_addr[ADDR_W-1:2];
    case (i_st_type)
      3'b000: begin
        fmt_c.wdata = {4{i_st_data[7:0]}};
        fmt_c.bmask = 4'b0001 << i_st_addr[1:0];
      end
      3'b001: begin
        illegal_c   = i_st_addr[0];
        fmt_c.wdata = {2{i_st_data[15:0]}};
        fmt_c.bmask = i_st_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        illegal_c   = |i_st_addr[1:0];
        fmt_c.wdata = i_st_data;
        fmt_c.bmask = 4'b1111;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mem_q    <= '{default: '0};
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept_c && illegal_c;
      if (enq_c) begin
        mem_q[wr_ptr_q] <= fmt_c;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (deq_c) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      case ({enq_c, deq_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_st_ready   = !full_c;
  assign o_st_err     = err_q;
  assign o_dmem_req   = !empty_c;
  assign o_busy       = !empty_c;
  assign o_dmem_addr  = {mem_q[rd_ptr_q].word, 2'b00};
  assign o_dmem_wdata = mem_q[rd_ptr_q].wdata;
  assign o_dmem_bmask = mem_q[rd_ptr_q].bmask;

`ifdef STORE_HAZARD_EN
  // Any pending store to the load's word stalls the load
  logic [DEPTH-1:0] hit_c;
  logic             unused_ld;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_hz
    assign hit_c[g] = vld_q[g] && (mem_q[g].word == i_ld_addr[ADDR_W-1:2]);
  end

  assign o_ld_hazard = |hit_c;
  assign unused_ld   = ^i_ld_addr[1:0];
`else
  logic unused_ld;
  logic unused_vld;

  assign o_ld_hazard = 1'b0;
  assign unused_ld   = ^i_ld_addr;
  assign unused_vld  = ^vld_q;
`endif

endmodule
